pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
Sequences control-flow redirects from the EXE stage into the fetch unit: JAL, JALR and taken branches. Selects and aligns the target, and holds the redirect until instruction fetch accepts it. Generates IF/ID and ID/EXE flush pulses, including squash cycles for wrong-path fetches already in flight. Sits between EXE (ALU/branch unit), the PC register and the IF/ID, ID/EXE pipeline registers.

Parameters:
DATA_W, 32, PC/target width (equals `data_size)
FETCH_LAT, 1, wrong-path fetches in flight after a redirect is accepted; legal range 0..7
CNT_W, 32, width of redirect performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
exe_valid  in  1  EXE stage holds a valid instruction
stall_exe  in  1  EXE stalled by hazard unit; instruction must not be acted on
opcode_exe  in  7  opcode of EXE instruction (`JAL, `JALR, `BRANCH)
branch_taken  in  1  branch comparator result for EXE instruction
pc_jump  in  DATA_W  PC-relative target (branch/JAL)
alu_result  in  DATA_W  rs1+imm (JALR target)
if_ready  in  1  fetch unit accepts a new PC this cycle
pc_redirect  out  1  load pc_target into PC this cycle
pc_target  out  DATA_W  redirect target
flush_if_id  out  1  invalidate IF/ID register
flush_id_exe  out  1  invalidate ID/EXE register
misalign_exc  out  1  one-cycle pulse: target not 4-byte aligned
redirect_busy  out  1  controller in HOLD or SQUASH
redirect_count  out  CNT_W  number of redirects accepted by fetch

Behaviour:
- Reset (rst_n low, async): state=IDLE, held target=0, squash count=0, redirect_count=0. All outputs 0 while rst_n low, regardless of inputs.
- req = exe_valid & ~stall_exe & state==IDLE & (opcode==`JAL | opcode==`JALR | (opcode==`BRANCH & branch_taken)).
- Target: JALR -> {alu_result[DATA_W-1:1],1'b0}. Otherwise pc_jump.
- Misalignment: if target[1]==1, pulse misalign_exc for the req cycle. pc_target shows the target. No redirect, no flush, state stays IDLE.
- States IDLE, HOLD, SQUASH:
- IDLE, aligned req, if_ready=1 (same cycle, combinational): pc_redirect=1, pc_target=target, flush_if_id=1, flush_id_exe=1, redirect_count+1. Next state: SQUASH with count=FETCH_LAT-1 if FETCH_LAT>0, else IDLE.
- IDLE, aligned req, if_ready=0: flush_if_id=1, flush_id_exe=1, pc_redirect=1, target latched. Next state HOLD.
- HOLD: pc_redirect=1, pc_target=latched target, flush_if_id=1, flush_id_exe=1.
  - if_ready=1: redirect_count+1, go to SQUASH (or IDLE if FETCH_LAT=0).
  - Otherwise stay in HOLD.
- SQUASH: flush_if_id=1, pc_redirect=0, flush_id_exe=0. If count==0 go to IDLE, else count-1. Total squash cycles = FETCH_LAT.
- In HOLD and SQUASH, EXE inputs are ignored (wrong-path). redirect_busy=1.
- stall_exe=1 in IDLE: no action. Redirect taken on the first unstalled cycle.
- pc_target=0 whenever pc_redirect=0 and misalign_exc=0.
- redirect_count wraps modulo 2^CNT_W.
- Reset asserted mid-HOLD/SQUASH aborts immediately to IDLE. The pending target is discarded.

Test Plan:
- JALR, alu_result=0x0000_1235, if_ready=1, FETCH_LAT=1 -> same cycle pc_redirect=1, pc_target=0x1234, both flushes=1. Next cycle flush_if_id=1 only. Then IDLE. redirect_count=1.
- BEQ taken, pc_jump=0x200, if_ready=0 for 3 cycles then 1 -> pc_redirect/flushes held 4 cycles with target 0x200. One SQUASH cycle follows. EXE requests during HOLD are ignored.
- BEQ not taken, or stall_exe=1 with JAL -> no outputs asserted. Releasing the stall gives a redirect on that cycle.
- JAL with pc_jump=0x102 -> misalign_exc 1 cycle, pc_target=0x102, pc_redirect=0, state IDLE.
- FETCH_LAT=3 with back-to-back JALs in EXE -> exactly 3 SQUASH cycles. The second JAL is ignored. redirect_count=1.
- rst_n deasserted-low during HOLD -> outputs 0 immediately. After release, state IDLE and redirect_count=0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences EXE control-flow redirects (JAL/JALR/taken branch) into fetch with flush/squash
//   in : clk, rst_n (async, active low), exe_valid, stall_exe, opcode_exe, branch_taken,
//        pc_jump (branch/JAL target), alu_result (JALR target), if_ready (fetch accepts PC)
//   out: pc_redirect, pc_target, flush_if_id, flush_id_exe, misalign_exc, redirect_busy, redirect_count
module pc_redirect_ctrl #(
  parameter int DATA_W    = 32,
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exe_valid,
  input  logic              stall_exe,
  input  logic [6:0]        opcode_exe,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] pc_jump,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              if_ready,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush_if_id,
  output logic              flush_id_exe,
  output logic              misalign_exc,
  output logic              redirect_busy,
  output logic [CNT_W-1:0]  redirect_count
);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {IDLE, HOLD, SQUASH} state_t;
  // Squash counter preload and the state entered once fetch takes the redirect.
  localparam logic [2:0] SQ_INIT = FETCH_LAT > 0 ? 3'(FETCH_LAT - 1) : 3'd0;
  localparam state_t     AFTER   = FETCH_LAT > 0 ? SQUASH : IDLE;
  state_t state, state_nx;
  logic [DATA_W-1:0] held, held_nx, target, tgt;
  logic [2:0] sq, sq_nx;
  logic [CNT_W-1:0] cnt;
  logic is_jalr, req, redir, f_if, f_ie, mis, acc;
  assign is_jalr = opcode_exe == OP_JALR;
  assign req = exe_valid & ~stall_exe & (state == IDLE) &
               (opcode_exe == OP_JAL | is_jalr | (opcode_exe == OP_BRANCH & branch_taken));
  assign target = is_jalr ? {alu_result[DATA_W-1:1], 1'b0} : pc_jump;
  always_comb begin
    state_nx = state;
    held_nx  = held;
    sq_nx    = sq;
    redir    = 1'b0;
    tgt      = '0;
    f_if     = 1'b0;
    f_ie     = 1'b0;
    mis      = 1'b0;
    acc      = 1'b0;
    case (state)
      IDLE: if (req) begin
        tgt = target;
        if (target[1]) mis = 1'b1;
        else begin
          redir    = 1'b1;
          f_if     = 1'b1;
          f_ie     = 1'b1;
          acc      = if_ready;
          held_nx  = target;
          sq_nx    = SQ_INIT;
          state_nx = if_ready ? AFTER : HOLD;
        end
      end
      HOLD: begin
        redir    = 1'b1;
        tgt      = held;
        f_if     = 1'b1;
        f_ie     = 1'b1;
        acc      = if_ready;
        sq_nx    = SQ_INIT;
        state_nx = if_ready ? AFTER : HOLD;
      end
      SQUASH: begin
        f_if     = 1'b1;
        sq_nx    = sq == 3'd0 ? 3'd0 : sq - 3'd1;
        state_nx = sq == 3'd0 ? IDLE : SQUASH;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      held  <= '0;
      sq    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      held  <= held_nx;
      sq    <= sq_nx;
      cnt   <= cnt + CNT_W'(acc);
    end
  // Combinational outputs are gated so everything reads 0 while reset is held.
  assign pc_redirect    = rst_n & redir;
  assign pc_target      = rst_n ? tgt : '0;
  assign flush_if_id    = rst_n & f_if;
  assign flush_id_exe   = rst_n & f_ie;
  assign misalign_exc   = rst_n & mis;
  assign redirect_busy  = rst_n & (state != IDLE);
  assign redirect_count = cnt;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: scoreboard bench driving FETCH_LAT=1 and FETCH_LAT=3 instances in parallel
module tb_pc_redirect_ctrl;
  localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
  // flag order: redirect, flush_if_id, flush_id_exe, misalign, busy
  localparam logic [4:0] N = 5'b00000, R = 5'b11100, H = 5'b11101, S = 5'b01001, M = 5'b00010;
  typedef struct packed {
    logic [4:0]  f;
    logic [31:0] tgt;
    logic [31:0] cnt;
  } obs_t;
  typedef struct {
    int   id;
    obs_t a;
    obs_t b;
  } rec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic exe_valid = 0, stall_exe = 0, branch_taken = 0, if_ready = 0;
  logic [6:0] opcode_exe = '0;
  logic [31:0] pc_jump = '0, alu_result = '0;
  logic redir_a, fif_a, fie_a, mis_a, busy_a, redir_b, fif_b, fie_b, mis_b, busy_b;
  logic [31:0] tgt_a, cnt_a, tgt_b, cnt_b;
  rec_t q[$];
  rec_t r;
  int id = 0, checks = 0, passed = 0;
  always #5 clk = ~clk;
  pc_redirect_ctrl #(.DATA_W(32), .FETCH_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .stall_exe(stall_exe), .opcode_exe(opcode_exe),
    .branch_taken(branch_taken), .pc_jump(pc_jump), .alu_result(alu_result), .if_ready(if_ready),
    .pc_redirect(redir_a), .pc_target(tgt_a), .flush_if_id(fif_a), .flush_id_exe(fie_a),
    .misalign_exc(mis_a), .redirect_busy(busy_a), .redirect_count(cnt_a));
  pc_redirect_ctrl #(.DATA_W(32), .FETCH_LAT(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .stall_exe(stall_exe), .opcode_exe(opcode_exe),
    .branch_taken(branch_taken), .pc_jump(pc_jump), .alu_result(alu_result), .if_ready(if_ready),
    .pc_redirect(redir_b), .pc_target(tgt_b), .flush_if_id(fif_b), .flush_id_exe(fie_b),
    .misalign_exc(mis_b), .redirect_busy(busy_b), .redirect_count(cnt_b));
  function automatic obs_t o(input logic [4:0] f, input logic [31:0] t, input logic [31:0] c);
    return obs_t'({f, t, c});
  endfunction
  task automatic chk(input int n, input string d, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL vec%0d dut_%s: got flags=%b tgt=%h cnt=%0d, want flags=%b tgt=%h cnt=%0d",
                  n, d, act.f, act.tgt, act.cnt, exp.f, exp.tgt, exp.cnt);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      r = q.pop_front();
      chk(r.id, "a", o({redir_a, fif_a, fie_a, mis_a, busy_a}, tgt_a, cnt_a), r.a);
      chk(r.id, "b", o({redir_b, fif_b, fie_b, mis_b, busy_b}, tgt_b, cnt_b), r.b);
    end
  task automatic drv(input logic v, input logic s, input logic [6:0] op, input logic tk,
                     input logic [31:0] pj, input logic [31:0] alu, input logic rdy);
    exe_valid = v; stall_exe = s; opcode_exe = op; branch_taken = tk;
    pc_jump = pj; alu_result = alu; if_ready = rdy;
  endtask
  task automatic cyc(input obs_t a, input obs_t b);
    q.push_back('{id, a, b});
    id++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input obs_t a, input obs_t b);
    drv(0, 0, 7'h0, 0, 32'h0, 32'h0, 1);
    cyc(a, b);
  endtask
  initial begin
    @(posedge clk);
    #1;
    // reset held: outputs zero despite an active JAL
    drv(1, 0, JAL, 0, 32'h300, 32'h0, 1);           cyc(o(N, 0, 0), o(N, 0, 0));
    rst_n = 1'b1;
    idle(o(N, 0, 0), o(N, 0, 0));
    // JALR with odd alu_result, fetch ready
    drv(1, 0, JALR, 0, 32'h0, 32'h1235, 1);         cyc(o(R, 32'h1234, 0), o(R, 32'h1234, 0));
    idle(o(S, 0, 1), o(S, 0, 1));
    idle(o(N, 0, 1), o(S, 0, 1));
    idle(o(N, 0, 1), o(S, 0, 1));
    // taken branch held 4 cycles; JAL during HOLD ignored
    drv(1, 0, BR, 1, 32'h200, 32'h0, 0);            cyc(o(R, 32'h200, 1), o(R, 32'h200, 1));
    drv(1, 0, JAL, 0, 32'h444, 32'h0, 0);           cyc(o(H, 32'h200, 1), o(H, 32'h200, 1));
    cyc(o(H, 32'h200, 1), o(H, 32'h200, 1));
    if_ready = 1'b1;                                 cyc(o(H, 32'h200, 1), o(H, 32'h200, 1));
    idle(o(S, 0, 2), o(S, 0, 2));
    idle(o(N, 0, 2), o(S, 0, 2));
    idle(o(N, 0, 2), o(S, 0, 2));
    // branch not taken, stalled JAL, then stall released
    drv(1, 0, BR, 0, 32'h500, 32'h0, 1);            cyc(o(N, 0, 2), o(N, 0, 2));
    drv(1, 1, JAL, 0, 32'h600, 32'h0, 1);           cyc(o(N, 0, 2), o(N, 0, 2));
    stall_exe = 1'b0;                                cyc(o(R, 32'h600, 2), o(R, 32'h600, 2));
    idle(o(S, 0, 3), o(S, 0, 3));
    idle(o(N, 0, 3), o(S, 0, 3));
    idle(o(N, 0, 3), o(S, 0, 3));
    // misaligned JAL and JALR targets
    drv(1, 0, JAL, 0, 32'h102, 32'h0, 1);           cyc(o(M, 32'h102, 3), o(M, 32'h102, 3));
    drv(1, 0, JALR, 0, 32'h0, 32'h1237, 1);         cyc(o(M, 32'h1236, 3), o(M, 32'h1236, 3));
    idle(o(N, 0, 3), o(N, 0, 3));
    // back-to-back JALs: lat1 retakes after its single squash, lat3 squashes 3 cycles
    drv(1, 0, JAL, 0, 32'h800, 32'h0, 1);           cyc(o(R, 32'h800, 3), o(R, 32'h800, 3));
    drv(1, 0, JAL, 0, 32'h900, 32'h0, 1);           cyc(o(S, 0, 4), o(S, 0, 4));
    cyc(o(R, 32'h900, 4), o(S, 0, 4));
    cyc(o(S, 0, 5), o(S, 0, 4));
    idle(o(N, 0, 5), o(N, 0, 4));
    // async reset during HOLD
    drv(1, 0, JAL, 0, 32'hA00, 32'h0, 0);           cyc(o(R, 32'hA00, 5), o(R, 32'hA00, 4));
    drv(0, 0, 7'h0, 0, 32'h0, 32'h0, 0);            cyc(o(H, 32'hA00, 5), o(H, 32'hA00, 4));
    rst_n = 1'b0;
    drv(1, 0, JAL, 0, 32'hB00, 32'h0, 1);           cyc(o(N, 0, 0), o(N, 0, 0));
    rst_n = 1'b1;
    idle(o(N, 0, 0), o(N, 0, 0));
    drv(1, 0, JAL, 0, 32'h40, 32'h0, 1);            cyc(o(R, 32'h40, 0), o(R, 32'h40, 0));
    idle(o(S, 0, 1), o(S, 0, 1));
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d records left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1);
  end
endmodule
